// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures the duty of an asynchronous PWM input as the
// number of high clk samples per PWM period. Reports a fresh duty value with
// a one-cycle valid pulse on each correctly spaced rising edge, reports 0%
// duty after PERIOD consecutive low samples, and flags period violations or
// missing edges with a one-cycle err pulse.
module pwm_duty_meter #(
  parameter int PERIOD = 16,
  parameter int DW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m,
  output logic [DW-1:0] duty_out,
  output logic          valid,
  output logic          err
);

  // cnt and lowrun must be able to hold PERIOD itself (up to 2^DW).
  localparam int CW = DW + 1;
  localparam logic [CW-1:0] PER_C = CW'(PERIOD);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_sync1;
  logic r_sync2;
  logic r_sprev;
  logic w_s;
  logic w_rise;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_lowrun;
  // hcnt only needs DW bits: at a well-spaced rise it is at most PERIOD-1.
  // It may wrap in a stuck-high window, but that window always ends in err
  // and its hcnt is never reported.
  logic [DW-1:0] r_hcnt;

  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_lowrun_nxt;
  logic [DW-1:0] w_hcnt_nxt;
  logic [DW-1:0] w_duty_nxt;
  logic          w_valid_nxt;
  logic          w_err_nxt;

  assign w_s    = r_sync2;
  assign w_rise = r_sync2 & ~r_sprev;

  // Next-state, counter and output decode for the IDLE/MEAS lock FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hcnt_nxt   = r_hcnt;
    w_lowrun_nxt = r_lowrun;
    w_duty_nxt   = duty_out;
    w_valid_nxt  = 1'b0;
    w_err_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = MEAS;
          w_cnt_nxt   = ONE_C;
          w_hcnt_nxt  = DW'(1);
        end else if (!w_s) begin
          if (r_lowrun + ONE_C == PER_C) begin
            // A full period of low samples is a legitimate 0% duty report.
            w_valid_nxt  = 1'b1;
            w_duty_nxt   = '0;
            w_lowrun_nxt = '0;
          end else begin
            w_lowrun_nxt = r_lowrun + ONE_C;
          end
        end else begin
          w_lowrun_nxt = '0;
        end
      end

      MEAS: begin
        if (w_rise) begin
          if (r_cnt == PER_C) begin
            w_valid_nxt = 1'b1;
            w_duty_nxt  = r_hcnt;
          end else begin
            // Edge arrived early or late: flag it and re-lock to this edge.
            w_err_nxt = 1'b1;
          end
          w_cnt_nxt  = ONE_C;
          w_hcnt_nxt = DW'(1);
        end else if (r_cnt < PER_C) begin
          w_cnt_nxt  = r_cnt + ONE_C;
          w_hcnt_nxt = r_hcnt + DW'(w_s);
        end else begin
          // Expected edge never came: drop lock. A low sample here already
          // counts toward the 0% run.
          w_err_nxt    = 1'b1;
          w_state_nxt  = IDLE;
          w_lowrun_nxt = w_s ? '0 : ONE_C;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Synchronizer, edge history, FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sprev  <= 1'b0;
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hcnt   <= '0;
      r_lowrun <= '0;
      duty_out <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      r_sync1  <= m;
      r_sync2  <= r_sync1;
      r_sprev  <= r_sync2;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hcnt   <= w_hcnt_nxt;
      r_lowrun <= w_lowrun_nxt;
      duty_out <= w_duty_nxt;
      valid    <= w_valid_nxt;
      err      <= w_err_nxt;
    end
  end

endmodule

// File: doc/pwm_duty_meter.md
PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

Interface
REQ-001 The parameter PERIOD SHALL default to 16 and give the expected PWM period in clk cycles; legal range is 4..2^DW.
REQ-002 The parameter DW SHALL default to 4 and give the width of duty_out.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 m  input  1  PWM waveform to measure; asynchronous to clk.
REQ-006 duty_out  output  DW  last measured high-sample count per period.
REQ-007 valid  output  1  one-cycle pulse when duty_out has been updated.
REQ-008 err  output  1  one-cycle pulse on a period violation or a lost edge.

Function
REQ-009 m SHALL pass through a 2-flop synchronizer; the second flop is sample s, and s_prev holds s delayed by one cycle.
REQ-010 A rising edge SHALL be defined as rise = s & ~s_prev.
REQ-011 The FSM SHALL have two states:
- IDLE: unlocked.
- MEAS: locked to the last rising edge.
REQ-012 Counters SHALL be:
- cnt: samples since the last rise, including the rise sample.
- hcnt: high samples in that same window.
- lowrun: consecutive low samples, used in IDLE.
REQ-013 IDLE behaviour:
- On rise: go to MEAS, set cnt=1 and hcnt=1, no output pulse.
- On a low sample: lowrun increments.
- On a high non-rise sample: lowrun clears.
REQ-014 IDLE, lowrun reaching PERIOD: pulse valid with duty_out=0, then clear lowrun (0% duty reports every PERIOD samples).
REQ-015 MEAS, rise with cnt==PERIOD: load duty_out=hcnt, pulse valid, set cnt=1 and hcnt=1, stay in MEAS.
REQ-016 MEAS, rise with cnt!=PERIOD: pulse err, leave duty_out unchanged, set cnt=1 and hcnt=1, stay in MEAS (re-lock to this edge).
REQ-017 MEAS, non-rise sample with cnt<PERIOD: cnt increments and hcnt adds s.
REQ-018 MEAS, non-rise sample with cnt==PERIOD (missing edge, e.g. a drop to 0% or stuck high): pulse err, go to IDLE, clear lowrun; if s==0, lowrun is set to 1.
REQ-019 hcnt at a valid rise SHALL be at most PERIOD-1 (the sample before a rise is low), so it always fits in DW bits with no saturation logic.
REQ-020 valid and err SHALL never assert in the same cycle, and each SHALL be high for exactly one cycle per event.
REQ-021 duty_out, valid and err SHALL all be registered.
REQ-022 Latency: valid/err SHALL assert on the 3rd rising clk edge after the edge that first samples the triggering m level (2 cycles of sync + 1 register).
REQ-023 duty_out SHALL hold its value between valid pulses, including across err pulses and IDLE periods.

Reset
REQ-024 While rst is high at a clk edge, the design SHALL clear:
- sync flops, s_prev, cnt, hcnt and lowrun to 0;
- state to IDLE;
- duty_out, valid and err to 0.
REQ-025 A reset mid-measurement SHALL discard the partial window, and the first valid SHALL require two rises spaced PERIOD apart (or PERIOD low samples for duty 0).
REQ-026 If m is already high when rst deasserts, the first synchronized high sample SHALL count as a rise.

Verification
REQ-027 PWM, PERIOD 16, m high 5 of 16 cycles, repeated -> after the second rise, valid every 16 cycles with duty_out=5, err never set.
REQ-028 m held low from reset -> valid every 16 cycles with duty_out=0.
REQ-029 Duty 3 for 3 periods, then 12 -> duty_out reports 3, then 12 on the first valid after the first 12-high period, with no err.
REQ-030 Pulses with a 12-cycle period -> err at each rise after lock, no valid, duty_out unchanged.
REQ-031 Duty 7 locked, then m stuck high -> exactly one err 16 samples after the last rise, then no further pulses; a return to 16-cycle PWM re-locks and resumes valid.
REQ-032 rst asserted mid-period while locked at duty 9 -> outputs 0 the cycle after, and the next valid (duty_out=9) only after two fresh rises.
